// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared line/word geometry, FSM state codes and word-select helper
package line_mem_responder_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int OFF_W      = 3;
    localparam int ADDR_W     = 30;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READ      = 3'd1;
    localparam logic [2:0] ST_READ_LAST = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  idx);
        return line[{idx, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/line_word_buffer.sv
// rtl/line_word_buffer.sv - 8x32 line register file, indexed word write, parallel read-out
module line_word_buffer
    import line_mem_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [OFF_W-1:0]     idx_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [LINE_W-1:0]    line_o
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (we_i) begin
            words_q[idx_i] <= wdata_i;
        end
    end

    assign line_o = words_q;

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - cache line fill/writeback responder over a 32-bit word memory; LINE_MEM_WRAP_FIRST_EN enables critical-word-first fills
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_MASK = 30'h3FFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ram_en,
    input  logic                 ram_write,
    input  logic [ADDR_W-1:0]    ram_addr,
    input  logic [LINE_W-1:0]    line_wb,
    output logic                 ram_ready,
    output logic [LINE_W-1:0]    block_out,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata,
    output logic [2:0]           status,
    output logic [OFF_W-1:0]     counter
);

    logic [2:0]          st_q,   st_d;
    logic [OFF_W-1:0]    cnt_q,  cnt_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic [OFF_W-1:0]    prev_q, prev_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   wb_q,   wb_d;
    logic [OFF_W-1:0]    fill_start;
    logic                buf_we;

`ifdef LINE_MEM_WRAP_FIRST_EN
    assign fill_start = ram_addr[OFF_W-1:0];
`else
    assign fill_start = '0;
`endif

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        prev_d = prev_q;
        base_d = base_q;
        wb_d   = wb_q;
        buf_we = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (ram_en) begin
                    base_d = (ram_addr & ~30'd7) & BASE_MASK;
                    wb_d   = line_wb;
                    beat_d = '0;
                    cnt_d  = ram_write ? '0 : fill_start;
                    st_d   = ram_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                // Read data lags the address by one cycle, so beat n lands while beat n+1 is issued.
                buf_we = (beat_q != '0);
                prev_d = cnt_q;
                cnt_d  = cnt_q + 3'd1;
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) st_d = ST_READ_LAST;
            end
            ST_READ_LAST: begin
                buf_we = 1'b1;
                cnt_d  = '0;
                st_d   = ST_DONE;
            end
            ST_WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) st_d = ST_DONE;
            end
            ST_DONE: st_d = ST_HOLD;
            ST_HOLD: if (!ram_en) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            beat_q <= '0;
            prev_q <= '0;
            base_q <= '0;
            wb_q   <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
            prev_q <= prev_d;
            base_q <= base_d;
            wb_q   <= wb_d;
        end
    end

    line_word_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (buf_we),
        .idx_i   (prev_q),
        .wdata_i (mem_rdata),
        .line_o  (block_out)
    );

    assign mem_en    = (st_q == ST_READ) || (st_q == ST_WRITE);
    assign mem_we    = (st_q == ST_WRITE);
    assign mem_addr  = mem_en ? base_q + {{(ADDR_W-OFF_W){1'b0}}, cnt_q} : '0;
    assign mem_wdata = mem_we ? line_word(wb_q, cnt_q) : '0;
    assign ram_ready = (st_q == ST_DONE);
    assign status    = st_q;
    assign counter   = cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - vector table plus access scoreboard for line_mem_responder
module tb_line_mem_responder;

    logic          clk;
    logic          rst;
    logic          ram_en;
    logic          ram_write;
    logic [29:0]   ram_addr;
    logic [255:0]  line_wb;
    logic          ram_ready;
    logic [255:0]  block_out;
    logic          mem_en;
    logic          mem_we;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [2:0]    status;
    logic [2:0]    counter;

    line_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ram_en    (ram_en),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .line_wb   (line_wb),
        .ram_ready (ram_ready),
        .block_out (block_out),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .status    (status),
        .counter   (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory model: word[a] = a, registered read.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= {2'b00, mem_addr};
    end

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] seed;
        bit          toggle;
        int          hold;
        int          exp_lat;
    } vec_t;

    int            checks;
    int            errors;
    int            ready_cnt;
    acc_t          exp_q[$];
    logic [255:0]  exp_block;
    vec_t          vecs[7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        acc_t e;
        if (ram_ready) ready_cnt++;
        if (mem_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_access unexpected actual addr=%0h we=%0b required none", mem_addr, mem_we);
            end else begin
                e = exp_q.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                    errors++;
                    $display("FAIL mem_access actual we=%0b addr=%0h data=%0h required we=%0b addr=%0h data=%0h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_expected(input vec_t v, output logic [255:0] wbl);
        logic [29:0] base;
        logic [2:0]  off;
        acc_t        a;
        base = v.addr & ~30'd7;
        for (int i = 0; i < 8; i++) wbl[32*i +: 32] = v.seed + 32'(i);
`ifdef LINE_MEM_WRAP_FIRST_EN
        off = v.wr ? 3'd0 : v.addr[2:0];
`else
        off = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            a.we   = v.wr;
            a.addr = base + {27'd0, off};
            a.data = v.wr ? wbl[{off, 5'b0} +: 32] : 32'd0;
            exp_q.push_back(a);
            off = off + 3'd1;
        end
        if (!v.wr) begin
            for (int i = 0; i < 8; i++) exp_block[32*i +: 32] = {2'b00, base + 30'(i)};
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [255:0] wbl;
        int           lat;
        int           r0;
        push_expected(v, wbl);
        @(posedge clk);
        #1;
        ram_en    = 1'b1;
        ram_write = v.wr;
        ram_addr  = v.addr;
        line_wb   = wbl;
        r0        = ready_cnt;
        lat       = -1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, " accept_state"}, 256'(status), 256'(3'd0));
            if (ram_ready) begin
                lat = c;
                break;
            end
            if (v.toggle && c >= 1) begin
                ram_addr  = 30'($urandom());
                ram_write = ~ram_write;
                line_wb   = {8{32'($urandom())}};
            end
        end
        chk({tag, " latency"}, 256'(lat), 256'(v.exp_lat));
        chk({tag, " block_out"}, block_out, exp_block);
        for (int h = 0; h <= v.hold; h++) begin
            @(negedge clk);
            if (v.toggle) begin
                ram_addr = 30'($urandom());
                line_wb  = {8{32'($urandom())}};
            end
        end
        chk({tag, " hold_state"}, 256'(status), 256'(3'd5));
        chk({tag, " block_out_held"}, block_out, exp_block);
        @(posedge clk);
        #1;
        ram_en = 1'b0;
        @(negedge clk);
        chk({tag, " hold_until_drop"}, 256'(status), 256'(3'd5));
        @(negedge clk);
        chk({tag, " idle_after_drop"}, 256'(status), 256'(3'd0));
        chk({tag, " ready_pulses"}, 256'(ready_cnt - r0), 256'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ram_ready"}, 256'(ram_ready), 256'(0));
        chk({tag, " mem_en_we"}, 256'({mem_en, mem_we}), 256'(0));
        chk({tag, " mem_addr"}, 256'(mem_addr), 256'(0));
        chk({tag, " mem_wdata"}, 256'(mem_wdata), 256'(0));
        chk({tag, " block_out"}, block_out, 256'(0));
        chk({tag, " status_counter"}, 256'({status, counter}), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   r0;
        vec_t rv;
        acc_t dummy;
        logic [255:0] wtmp;
        checks    = 0;
        errors    = 0;
        ready_cnt = 0;
        exp_block = '0;
        rst       = 1'b0;
        ram_en    = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        line_wb   = '0;

        vecs[0] = '{wr: 1'b0, addr: 30'h100,        seed: 32'h0,         toggle: 1'b0, hold: 0,  exp_lat: 10};
        vecs[1] = '{wr: 1'b1, addr: 30'h208,        seed: 32'hA5A5_0000, toggle: 1'b0, hold: 0,  exp_lat: 9};
        vecs[2] = '{wr: 1'b0, addr: 30'h105,        seed: 32'h0,         toggle: 1'b0, hold: 0,  exp_lat: 10};
        vecs[3] = '{wr: 1'b0, addr: 30'h2A3,        seed: 32'h0,         toggle: 1'b1, hold: 20, exp_lat: 10};
        vecs[4] = '{wr: 1'b1, addr: 30'h013,        seed: 32'h1234_5678, toggle: 1'b1, hold: 2,  exp_lat: 9};
        vecs[5] = '{wr: 1'b0, addr: 30'h3FFF_FFFE,  seed: 32'h0,         toggle: 1'b0, hold: 1,  exp_lat: 10};
        vecs[6] = '{wr: 1'b1, addr: 30'h3FFF_FFF8,  seed: 32'hFFFF_FFFC, toggle: 1'b0, hold: 0,  exp_lat: 9};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        for (int k = 0; k < 7; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

        // Reset in cycle 4 of a fill: partial line discarded, no ready pulse.
        rv = '{wr: 1'b0, addr: 30'h300, seed: 32'h0, toggle: 1'b0, hold: 0, exp_lat: 10};
        push_expected(rv, wtmp);
        @(posedge clk);
        #1;
        ram_en    = 1'b1;
        ram_write = 1'b0;
        ram_addr  = rv.addr;
        r0        = ready_cnt;
        for (int c = 0; c <= 4; c++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        while (exp_q.size() != 0) dummy = exp_q.pop_front();
        exp_block = '0;
        ram_en    = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset no_ready", 256'(ready_cnt - r0), 256'(0));
        rst = 1'b1;
        run_txn(vecs[0], "after_reset");

        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
